// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nto2n_seq
// Purpose  : Registered N-to-2^N decoder with one-hot, thermometer and timed
//            scan modes, handshake input and optional active-low outputs.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         sel,
    input  logic [1:0]           mode,
    output logic [(1<<N)-1:0]    y,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int c_width = 1 << N;
    localparam int c_cnt_w = $clog2(DWELL + 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_one  = c_cnt_w'(1);

    localparam logic [1:0] c_mode_onehot = 2'b00;
    localparam logic [1:0] c_mode_thermo = 2'b01;
    localparam logic [1:0] c_mode_scan   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_width-1:0]   r_y;
    logic                 r_y_valid;
    logic                 r_busy;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_dwell;
    logic [N-1:0]         r_pos;
    logic [N-1:0]         r_start;

    state_t               w_state_nx;
    logic [c_width-1:0]   w_y_nx;
    logic                 w_y_valid_nx;
    logic                 w_busy_nx;
    logic                 w_err_nx;
    logic [c_cnt_w-1:0]   w_dwell_nx;
    logic [N-1:0]         w_pos_nx;
    logic [N-1:0]         w_start_nx;

    logic                 w_accept;
    logic [N-1:0]         w_pos_inc;
    logic [c_width-1:0]   w_sel_onehot;
    logic [c_width-1:0]   w_sel_thermo;
    logic [c_width-1:0]   w_inc_onehot;

    assign in_ready  = en && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
    assign w_accept  = in_valid && in_ready;
    assign w_pos_inc = r_pos + N'(1);

    generate
        for (genvar k = 0; k < c_width; k++) begin : g_decode
            assign w_sel_onehot[k] = (sel == N'(k));
            assign w_sel_thermo[k] = (N'(k) <= sel);
            assign w_inc_onehot[k] = (w_pos_inc == N'(k));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_dwell   <= '0;
            r_pos     <= '0;
            r_start   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_y       <= w_y_nx;
            r_y_valid <= w_y_valid_nx;
            r_busy    <= w_busy_nx;
            r_err     <= w_err_nx;
            r_dwell   <= w_dwell_nx;
            r_pos     <= w_pos_nx;
            r_start   <= w_start_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_y_nx       = r_y;
        w_y_valid_nx = r_y_valid;
        w_busy_nx    = r_busy;
        w_err_nx     = 1'b0;
        w_dwell_nx   = r_dwell;
        w_pos_nx     = r_pos;
        w_start_nx   = r_start;

        if (!en) begin
            w_state_nx   = ST_IDLE;
            w_y_nx       = '0;
            w_y_valid_nx = 1'b0;
            w_busy_nx    = 1'b0;
            w_dwell_nx   = '0;
            w_pos_nx     = '0;
        end else if (w_accept) begin
            case (mode)
                c_mode_onehot: begin
                    w_state_nx   = ST_HOLD;
                    w_y_nx       = w_sel_onehot;
                    w_y_valid_nx = 1'b1;
                    w_busy_nx    = 1'b0;
                    w_dwell_nx   = '0;
                end
                c_mode_thermo: begin
                    w_state_nx   = ST_HOLD;
                    w_y_nx       = w_sel_thermo;
                    w_y_valid_nx = 1'b1;
                    w_busy_nx    = 1'b0;
                    w_dwell_nx   = '0;
                end
                c_mode_scan: begin
                    w_state_nx   = ST_SCAN;
                    w_y_nx       = w_sel_onehot;
                    w_y_valid_nx = 1'b1;
                    w_busy_nx    = 1'b1;
                    w_dwell_nx   = '0;
                    w_pos_nx     = sel;
                    w_start_nx   = sel;
                end
                default: begin
                    w_err_nx = 1'b1;
                end
            endcase
        end else if (r_state == ST_SCAN) begin
            if (r_dwell == c_dwell_last) begin
                w_dwell_nx = '0;
                // Wrapping back onto the start index means every position has been shown.
                if (w_pos_inc == r_start) begin
                    w_state_nx   = ST_IDLE;
                    w_y_nx       = '0;
                    w_y_valid_nx = 1'b0;
                    w_busy_nx    = 1'b0;
                    w_pos_nx     = '0;
                end else begin
                    w_pos_nx = w_pos_inc;
                    w_y_nx   = w_inc_onehot;
                end
            end else begin
                w_dwell_nx = r_dwell + c_dwell_one;
            end
        end
    end

    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign y = ~r_y;
        end else begin : g_active_high
            assign y = r_y;
        end
    endgenerate

    assign y_valid = r_y_valid;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: doc/decoder_nto2n_seq.md
DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

Interface
REQ-001 Parameter N, default 2: select width; output width is 2^N; legal range 1..6.
REQ-002 Parameter DWELL, default 4: cycles each output is held in scan mode; legal range 1..255.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every bit of y at the port; y_valid, busy and err are unaffected.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit, global enable; low forces all outputs inactive.
REQ-007 The block SHALL have port in_valid, input, 1 bit, a command is present on sel/mode.
REQ-008 The block SHALL have port in_ready, output, 1 bit, the block accepts a command this cycle.
REQ-009 The block SHALL have port sel, input, N bits, the select code.
REQ-010 The block SHALL have port mode, input, 2 bits: 00 one-hot, 01 thermometer, 10 scan, 11 reserved.
REQ-011 The block SHALL have port y, output, 2^N bits, the registered decoded outputs.
REQ-012 The block SHALL have port y_valid, output, 1 bit, y holds a decoded value.
REQ-013 The block SHALL have port busy, output, 1 bit, a scan is in progress.
REQ-014 The block SHALL have port err, output, 1 bit, one-cycle pulse on acceptance of reserved mode 11.

Function
REQ-015 The block SHALL accept a command when in_valid && in_ready && en at a rising edge; in_ready = en && (state == IDLE or HOLD).
REQ-016 States SHALL be IDLE (y inactive, y_valid 0), HOLD (static decode shown), SCAN (stepping).
REQ-017 Mode 00 accept: the block SHALL go to HOLD with y[k]=1 only for k=sel (internal polarity), y_valid=1; latency 1 cycle.
REQ-018 Mode 01 accept: the block SHALL go to HOLD with y[k]=1 for all k<=sel, y_valid=1; latency 1 cycle.
REQ-019 HOLD: y SHALL remain unchanged until the next accepted command, which takes effect on the following cycle with no idle gap.
REQ-020 Mode 10 accept: the block SHALL enter SCAN, with busy=1, in_ready=0 and y_valid=1 from the next cycle.
REQ-021 SCAN: y SHALL be one-hot at index p; p starts at sel and each output is held DWELL cycles.
REQ-022 SCAN: after DWELL cycles, p SHALL advance to (p+1) mod 2^N, wrapping from 2^N-1 to 0.
REQ-023 SCAN SHALL end after exactly 2^N positions (2^N*DWELL cycles); the block then enters IDLE with y inactive, y_valid=0, busy=0.
REQ-024 Mode 11 accept: state and y SHALL be unchanged and err SHALL pulse high for 1 cycle.
REQ-025 In_valid while in SCAN SHALL be ignored, not queued.
REQ-026 En low at any edge SHALL put the next state in IDLE, with y inactive, y_valid=0, busy=0 and a scan in progress aborted; no command is accepted that cycle.
REQ-027 Returning en high SHALL leave the block in IDLE until a new command is accepted.
REQ-028 The dwell counter SHALL be ceil(log2(DWELL+1)) bits wide; the position counter SHALL be N bits wide and wrap naturally.

Reset
REQ-029 rst_n low at a rising edge SHALL set state IDLE, y inactive (all 0, or all 1 if ACTIVE_LOW), and y_valid=0, busy=0, err=0, both counters 0.
REQ-030 Reset SHALL take priority over en and in_valid, including mid-scan.

Verification
REQ-031 N=2, en=1, mode=00, sel=2 for 1 cycle -> next cycle y=0100, y_valid=1, held until the next command.
REQ-032 N=2, mode=01, sel=2 -> y=0111; back-to-back mode=00, sel=3 -> y=1000 on the following cycle.
REQ-033 N=2, DWELL=2, mode=10, sel=3 -> y sequence 1000,1000,0001,0001,0010,0010,0100,0100, then y=0000, busy=0; in_ready=0 throughout.
REQ-034 En dropped on the 3rd scan cycle -> next cycle y=0000, busy=0, y_valid=0; an in_valid during en=0 is not accepted.
REQ-035 mode=11 while in HOLD with y=0010 -> err=1 for one cycle, y stays 0010; rst_n=0 mid-scan -> next cycle all outputs at reset values.
REQ-036 ACTIVE_LOW=1, N=3, mode=00, sel=5 -> y=11011111; idle y=11111111.
